// File: rtl/multi_timer.sv
// multi_timer: bank of independent hour:min:sec timers sharing one 1 Hz tick.
//
// Each channel holds a set value, a direction flag (up_r), a live count, a
// sticky alarm flag and a small state machine (IDLE, RUN, PAUSE, DONE).
// Commands address one channel through ch_sel; all running channels advance
// together on every cycle where tick is high.
//
// Ports
//   clk        : single clock, rising edge
//   cut_n      : synchronous reset, active-high (asserted when 1)
//   tick       : one-cycle 1 Hz count enable
//   ch_sel     : channel addressed by commands and by sec/min/hour readback
//   write      : load up/insec/inmin/inhour into the selected channel
//   up         : direction for the load (1 = count up, 0 = count down)
//   insec/inmin/inhour : target (up) or start value (down)
//   start/stop/alarm_ack : single-cycle commands to the selected channel
//   sec/min/hour : live count of the selected channel (0 when out of range)
//   alarm      : per-channel sticky completion flag
//   buzy_n     : per-channel, 0 while the channel is in RUN or PAUSE
//
// Configuration
//   TIMER_AUTORELOAD_EN : when defined, reaching the terminal value sets the
//   alarm, reloads the count and keeps the channel in RUN (periodic mode);
//   alarm_ack then clears only the alarm. When undefined, the channel stops
//   in DONE until acknowledged.

module multi_timer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                cut_n,
  input  logic                tick,
  input  logic [SEL_W-1:0]    ch_sel,
  input  logic                write,
  input  logic                up,
  input  logic [WIDTH-1:0]    insec,
  input  logic [WIDTH-1:0]    inmin,
  input  logic [WIDTH-1:0]    inhour,
  input  logic                start,
  input  logic                stop,
  input  logic                alarm_ack,
  output logic [WIDTH-1:0]    sec,
  output logic [WIDTH-1:0]    min,
  output logic [WIDTH-1:0]    hour,
  output logic [CHANNELS-1:0] alarm,
  output logic [CHANNELS-1:0] buzy_n
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_MS = WIDTH'(59);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  // Load values with minutes/seconds clamped into 0..59; shared by all channels.
  logic [WIDTH-1:0] ld_sec, ld_min;
  assign ld_sec = (insec > MAX_MS) ? MAX_MS : insec;
  assign ld_min = (inmin > MAX_MS) ? MAX_MS : inmin;

  logic [CHANNELS-1:0][WIDTH-1:0] sec_all, min_all, hour_all;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t           state_q, state_d;
      logic [WIDTH-1:0] set_sec_q, set_sec_d, set_min_q, set_min_d, set_hour_q, set_hour_d;
      logic [WIDTH-1:0] cnt_sec_q, cnt_sec_d, cnt_min_q, cnt_min_d, cnt_hour_q, cnt_hour_d;
      logic             up_q, up_d, alarm_q, alarm_d;

      logic             hit, do_write, do_start, do_stop, do_ack;
      logic [WIDTH-1:0] step_sec, step_min, step_hour;
      logic [WIDTH-1:0] rel_sec, rel_min, rel_hour;
      logic [WIDTH-1:0] tgt_sec, tgt_min, tgt_hour;
      logic             step_term, now_term;

      // Out-of-range ch_sel values never match any channel, so they are ignored.
      assign hit      = (ch_sel == SEL_W'(gi));
      assign do_write = hit & write;
      assign do_start = hit & start;
      assign do_stop  = hit & stop;
      assign do_ack   = hit & alarm_ack;

      // Reload value is the starting point; target is the terminal value.
      assign rel_sec  = up_q ? '0 : set_sec_q;
      assign rel_min  = up_q ? '0 : set_min_q;
      assign rel_hour = up_q ? '0 : set_hour_q;
      assign tgt_sec  = up_q ? set_sec_q  : '0;
      assign tgt_min  = up_q ? set_min_q  : '0;
      assign tgt_hour = up_q ? set_hour_q : '0;

      // One-second step with minute/hour carry or borrow.
      always_comb begin
        step_sec  = cnt_sec_q;
        step_min  = cnt_min_q;
        step_hour = cnt_hour_q;
        if (up_q) begin
          if (cnt_sec_q == MAX_MS) begin
            step_sec = '0;
            if (cnt_min_q == MAX_MS) begin
              step_min  = '0;
              step_hour = cnt_hour_q + ONE;
            end else begin
              step_min = cnt_min_q + ONE;
            end
          end else begin
            step_sec = cnt_sec_q + ONE;
          end
        end else begin
          if (cnt_sec_q == '0) begin
            step_sec = MAX_MS;
            if (cnt_min_q == '0) begin
              step_min  = MAX_MS;
              step_hour = cnt_hour_q - ONE;
            end else begin
              step_min = cnt_min_q - ONE;
            end
          end else begin
            step_sec = cnt_sec_q - ONE;
          end
        end
      end

      assign step_term = (step_sec == tgt_sec) && (step_min == tgt_min) && (step_hour == tgt_hour);
      assign now_term  = (cnt_sec_q == tgt_sec) && (cnt_min_q == tgt_min) && (cnt_hour_q == tgt_hour);

      always_comb begin
        state_d    = state_q;
        set_sec_d  = set_sec_q;
        set_min_d  = set_min_q;
        set_hour_d = set_hour_q;
        up_d       = up_q;
        cnt_sec_d  = cnt_sec_q;
        cnt_min_d  = cnt_min_q;
        cnt_hour_d = cnt_hour_q;
        alarm_d    = alarm_q;
`ifdef TIMER_AUTORELOAD_EN
        // Periodic mode: acknowledge clears only the flag; a set on the same
        // edge (below) overrides it.
        if (do_ack) alarm_d = 1'b0;
`endif
        unique case (state_q)
          ST_IDLE, ST_DONE: begin
            if (do_write) begin
              set_sec_d  = ld_sec;
              set_min_d  = ld_min;
              set_hour_d = inhour;
              up_d       = up;
              cnt_sec_d  = up ? '0 : ld_sec;
              cnt_min_d  = up ? '0 : ld_min;
              cnt_hour_d = up ? '0 : inhour;
              alarm_d    = 1'b0;
              state_d    = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
              if (do_start && !do_stop) begin
                state_d = ST_RUN;
                if (now_term) begin
                  alarm_d = 1'b1;
`ifndef TIMER_AUTORELOAD_EN
                  state_d = ST_DONE;
`endif
                end
              end
            end else if (do_ack) begin
              state_d    = ST_IDLE;
              alarm_d    = 1'b0;
              cnt_sec_d  = rel_sec;
              cnt_min_d  = rel_min;
              cnt_hour_d = rel_hour;
            end
          end
          ST_RUN: begin
            // stop has priority; the count is frozen on that edge.
            if (do_stop) begin
              state_d = ST_PAUSE;
            end else if (tick) begin
              cnt_sec_d  = step_sec;
              cnt_min_d  = step_min;
              cnt_hour_d = step_hour;
              if (step_term) begin
                alarm_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                cnt_sec_d  = rel_sec;
                cnt_min_d  = rel_min;
                cnt_hour_d = rel_hour;
`else
                state_d = ST_DONE;
`endif
              end
            end
          end
          ST_PAUSE: begin
            if (do_stop) begin
              state_d    = ST_IDLE;
              cnt_sec_d  = rel_sec;
              cnt_min_d  = rel_min;
              cnt_hour_d = rel_hour;
            end else if (do_start) begin
              state_d = ST_RUN;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (cut_n) begin
          state_q    <= ST_IDLE;
          set_sec_q  <= '0;
          set_min_q  <= '0;
          set_hour_q <= '0;
          up_q       <= 1'b0;
          cnt_sec_q  <= '0;
          cnt_min_q  <= '0;
          cnt_hour_q <= '0;
          alarm_q    <= 1'b0;
        end else begin
          state_q    <= state_d;
          set_sec_q  <= set_sec_d;
          set_min_q  <= set_min_d;
          set_hour_q <= set_hour_d;
          up_q       <= up_d;
          cnt_sec_q  <= cnt_sec_d;
          cnt_min_q  <= cnt_min_d;
          cnt_hour_q <= cnt_hour_d;
          alarm_q    <= alarm_d;
        end
      end

      assign sec_all[gi]  = cnt_sec_q;
      assign min_all[gi]  = cnt_min_q;
      assign hour_all[gi] = cnt_hour_q;
      assign alarm[gi]    = alarm_q;
      assign buzy_n[gi]   = !((state_q == ST_RUN) || (state_q == ST_PAUSE));
    end
  endgenerate

  // Readback mux; an unmatched ch_sel reads as zero.
  always_comb begin
    sec  = '0;
    min  = '0;
    hour = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == SEL_W'(i)) begin
        sec  = sec_all[i];
        min  = min_all[i];
        hour = hour_all[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed scoreboard bench for multi_timer.
// Stimulus pushes hand-computed expectations into a queue; a monitor on the
// falling edge pops each entry and compares it against the DUT outputs.

module tb_multi_timer;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                cut_n, tick, write, up, start, stop, alarm_ack;
  logic [SEL_W-1:0]    ch_sel;
  logic [WIDTH-1:0]    insec, inmin, inhour, sec, min, hour;
  logic [CHANNELS-1:0] alarm, buzy_n;

  multi_timer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk(clk), .cut_n(cut_n), .tick(tick), .ch_sel(ch_sel), .write(write), .up(up),
    .insec(insec), .inmin(inmin), .inhour(inhour), .start(start), .stop(stop),
    .alarm_ack(alarm_ack), .sec(sec), .min(min), .hour(hour), .alarm(alarm), .buzy_n(buzy_n)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] s;
    logic [15:0] m;
    logic [15:0] h;
    logic [3:0]  al;
    logic [3:0]  bz;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  // Monitor: consumes one expectation per falling edge.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if ({sec, min, hour, alarm, buzy_n} !== {e.s, e.m, e.h, e.al, e.bz}) begin
        bad++;
        $display("FAIL %s ch%0d: got %0d:%0d:%0d alarm=%b buzy_n=%b, want %0d:%0d:%0d alarm=%b buzy_n=%b",
                 n, e.ch, hour, min, sec, alarm, buzy_n, e.h, e.m, e.s, e.al, e.bz);
      end else begin
        $display("ok   %s ch%0d: %0d:%0d:%0d alarm=%b buzy_n=%b", n, e.ch, hour, min, sec, alarm, buzy_n);
      end
    end
  end

  // Queue an expectation for channel ch and give the monitor one falling edge.
  task automatic chk(input string n, input int ch, input int h, input int m, input int s,
                     input logic [3:0] al, input logic [3:0] bz);
    exp_t e;
    ch_sel = SEL_W'(ch);
    e.ch = 2'(ch);
    e.h  = 16'(h);
    e.m  = 16'(m);
    e.s  = 16'(s);
    e.al = al;
    e.bz = bz;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  // Immediate check of the per-channel flags.
  task automatic chk_flags(input string n, input logic [3:0] al, input logic [3:0] bz);
    total++;
    if ({alarm, buzy_n} !== {al, bz}) begin
      bad++;
      $display("FAIL %s: got alarm=%b buzy_n=%b, want alarm=%b buzy_n=%b", n, alarm, buzy_n, al, bz);
    end else begin
      $display("ok   %s: alarm=%b buzy_n=%b", n, alarm, buzy_n);
    end
  endtask

  task automatic op(input int ch, input logic w, input logic u, input int h, input int m, input int s,
                    input logic st, input logic sp, input logic ack, input logic tk);
    ch_sel    = SEL_W'(ch);
    write     = w;
    up        = u;
    inhour    = 16'(h);
    inmin     = 16'(m);
    insec     = 16'(s);
    start     = st;
    stop      = sp;
    alarm_ack = ack;
    tick      = tk;
    @(posedge clk);
    #1;
    write = 1'b0; start = 1'b0; stop = 1'b0; alarm_ack = 1'b0; tick = 1'b0;
  endtask

  task automatic wr(input int ch, input logic u, input int h, input int m, input int s);
    op(ch, 1'b1, u, h, m, s, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start(input int ch); op(ch, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_stop(input int ch);  op(ch, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_ack(input int ch);   op(ch, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0); endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Reset pulse with a start command asserted to show reset overrides it.
  task automatic pulse_reset();
    cut_n = 1'b1;
    ch_sel = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    cut_n = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    cut_n = 1'b1; tick = 1'b0; write = 1'b0; up = 1'b0; start = 1'b0; stop = 1'b0;
    alarm_ack = 1'b0; ch_sel = '0; insec = '0; inmin = '0; inhour = '0;
    repeat (3) @(posedge clk);
    #1;
    cut_n = 1'b0;
    chk_flags("reset_flags", 4'b0000, 4'b1111);
    chk("reset", 0, 0, 0, 0, 4'b0000, 4'b1111);

`ifdef TIMER_AUTORELOAD_EN
    wr(0, 1'b0, 0, 0, 2);
    do_start(0);
    ticks(1);
    chk("ar_first_tick", 0, 0, 0, 1, 4'b0000, 4'b1110);
    ticks(1);
    chk("ar_reload", 0, 0, 0, 2, 4'b0001, 4'b1110);
    chk_flags("ar_reload_flags", 4'b0001, 4'b1110);
    ticks(1);
    chk("ar_continues", 0, 0, 0, 1, 4'b0001, 4'b1110);
    do_ack(0);
    chk("ar_ack_keeps_run", 0, 0, 0, 1, 4'b0000, 4'b1110);
    do_stop(0);
    do_stop(0);
    chk("ar_stop_idle", 0, 0, 0, 2, 4'b0000, 4'b1111);
    pulse_reset();
    chk("ar_reset", 0, 0, 0, 0, 4'b0000, 4'b1111);
`else
    // Down count 0:0:3 on channel 0.
    wr(0, 1'b0, 0, 0, 3);
    chk("load_ch0", 0, 0, 0, 3, 4'b0000, 4'b1111);
    do_start(0);
    chk("run_ch0", 0, 0, 0, 3, 4'b0000, 4'b1110);
    ticks(2);
    chk("two_ticks_ch0", 0, 0, 0, 1, 4'b0000, 4'b1110);
    ticks(1);
    chk("done_ch0", 0, 0, 0, 0, 4'b0001, 4'b1111);
    chk_flags("done_ch0_flags", 4'b0001, 4'b1111);
    do_start(0);
    do_stop(0);
    chk("done_ignores_cmds", 0, 0, 0, 0, 4'b0001, 4'b1111);
    do_ack(0);
    chk("ack_ch0_reload", 0, 0, 0, 3, 4'b0000, 4'b1111);

    // Up count to 1:0:0 on channel 1.
    wr(1, 1'b1, 1, 0, 0);
    chk("load_ch1_up", 1, 0, 0, 0, 4'b0000, 4'b1111);
    do_start(1);
    ticks(59);
    chk("ch1_59s", 1, 0, 0, 59, 4'b0000, 4'b1101);
    ticks(1);
    chk("ch1_sec_roll", 1, 0, 1, 0, 4'b0000, 4'b1101);
    ticks(3539);
    chk("ch1_59m59s", 1, 0, 59, 59, 4'b0000, 4'b1101);
    ticks(1);
    chk("ch1_hour_done", 1, 1, 0, 0, 4'b0010, 4'b1111);
    do_ack(1);
    chk("ack_ch1", 1, 0, 0, 0, 4'b0000, 4'b1111);

    // Down count 0:1:0 on channel 2 with pause/resume.
    wr(2, 1'b0, 0, 1, 0);
    do_start(2);
    ticks(1);
    chk("ch2_borrow", 2, 0, 0, 59, 4'b0000, 4'b1011);
    ticks(4);
    chk("ch2_55", 2, 0, 0, 55, 4'b0000, 4'b1011);
    do_stop(2);
    ticks(10);
    chk("ch2_paused", 2, 0, 0, 55, 4'b0000, 4'b1011);
    do_start(2);
    chk("ch2_resume", 2, 0, 0, 55, 4'b0000, 4'b1011);
    ticks(1);
    chk("ch2_54", 2, 0, 0, 54, 4'b0000, 4'b1011);
    do_stop(2);
    do_stop(2);
    chk("ch2_stop_reload", 2, 0, 1, 0, 4'b0000, 4'b1111);
    do_start(2);
    wr(2, 1'b1, 9, 9, 9);
    chk("write_in_run_ignored", 2, 0, 1, 0, 4'b0000, 4'b1011);
    ticks(1);
    chk("dir_kept_down", 2, 0, 0, 59, 4'b0000, 4'b1011);
    do_stop(2);
    do_stop(2);
    op(2, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("start_stop_idle", 2, 0, 1, 0, 4'b0000, 4'b1111);

    // Channel 3: clamping, write+start, start at terminal.
    wr(3, 1'b0, 0, 70, 75);
    chk("clamp_59", 3, 0, 59, 59, 4'b0000, 4'b1111);
    op(3, 1'b1, 1'b0, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("write_with_start", 3, 0, 0, 5, 4'b0000, 4'b1111);
    wr(3, 1'b0, 0, 0, 0);
    do_start(3);
    chk("start_at_terminal", 3, 0, 0, 0, 4'b1000, 4'b1111);
    do_ack(3);
    chk("ack_ch3", 3, 0, 0, 0, 4'b0000, 4'b1111);

    // Alarm set and acknowledge on the same edge: the set wins.
    wr(0, 1'b0, 0, 0, 1);
    do_start(0);
    op(0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ack_same_edge", 0, 0, 0, 0, 4'b0001, 4'b1111);
    do_ack(0);
    chk("ack_after", 0, 0, 0, 1, 4'b0000, 4'b1111);

    // Concurrent channels, then reset mid-run.
    wr(0, 1'b0, 0, 0, 10);
    do_start(0);
    wr(3, 1'b1, 0, 5, 0);
    do_start(3);
    ticks(3);
    chk("conc_ch0", 0, 0, 0, 7, 4'b0000, 4'b0110);
    chk("conc_ch3", 3, 0, 0, 3, 4'b0000, 4'b0110);
    pulse_reset();
    chk("reset_mid_ch0", 0, 0, 0, 0, 4'b0000, 4'b1111);
    chk("reset_mid_ch3", 3, 0, 0, 0, 4'b0000, 4'b1111);
    chk("reset_mid_ch2", 2, 0, 0, 0, 4'b0000, 4'b1111);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter WIDTH, default 16, width of each hour/min/sec field.
REQ-002 Parameter CHANNELS, default 4, number of independent timer channels (1..16).
REQ-003 Parameter SEL_W, default $clog2(CHANNELS) (minimum 1), channel-select width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 cut_n  in  1  reset; synchronous, active-high (asserted when 1); the name is kept for continuity.
REQ-006 tick  in  1  one-cycle 1 Hz enable from an external prescaler; counters advance only on cycles with tick=1.
REQ-007 ch_sel  in  SEL_W  channel addressed by write/start/stop/alarm_ack and by the sec/min/hour readback.
REQ-008 write  in  1  loads up/insec/inmin/inhour into the selected channel.
REQ-009 up  in  1  direction for the load; 1=count up, 0=count down.
REQ-010 insec, inmin, inhour  in  WIDTH each  target (up) or start value (down).
REQ-011 start, stop, alarm_ack  in  1 each  single-cycle commands to the selected channel.
REQ-012 sec, min, hour  out  WIDTH each  live count of the selected channel (combinational mux).
REQ-013 alarm  out  CHANNELS  per-channel sticky completion flag.
REQ-014 buzy_n  out  CHANNELS  per-channel; 0 while the channel is in RUN or PAUSE.

Function
REQ-015 Each channel shall hold set registers, an up_r flag, a count, an alarm flag and a state in {IDLE, RUN, PAUSE, DONE}.
REQ-016 write shall be accepted only in IDLE or DONE: capture the inputs, clamp insec/inmin above 59 to 59, load count (0:0:0 if up, else the set value), clear alarm, go to IDLE; a write in RUN/PAUSE shall be ignored.
REQ-017 start in IDLE -> RUN; start in PAUSE -> RUN with the count retained; start in RUN/DONE shall be ignored.
REQ-018 stop in RUN -> PAUSE (count frozen); stop in PAUSE -> IDLE with the count reloaded per REQ-016; stop in IDLE/DONE shall be ignored.
REQ-019 start and stop in the same cycle: stop wins; write together with start in IDLE: write applies, start is ignored.
REQ-020 In RUN on tick, up mode: sec+1; at sec=59, sec=0 and min+1; at min=59 as well, min=0 and hour+1.
REQ-021 In RUN on tick, down mode: sec-1; at sec=0, sec=59 and min-1; at min=0 as well, min=59 and hour-1.
REQ-022 Terminal value is count==set (up) or count==0:0:0 (down); on the clock edge where RUN reaches the terminal value, state shall become DONE and alarm shall be set, both visible the following cycle.
REQ-023 start with terminal already met (e.g. set 0:0:0) shall go to DONE with alarm set one cycle later, with no counting.
REQ-024 In DONE the count shall hold its terminal value; alarm_ack clears alarm and returns to IDLE with the count reloaded.
REQ-025 alarm_ack outside DONE shall be ignored; alarm_ack on the same edge the alarm sets: the set wins.
REQ-026 Commands shall affect only the channel at ch_sel; all channels count concurrently on a shared tick.
REQ-027 ch_sel >= CHANNELS: commands shall be ignored and sec/min/hour shall read 0.
REQ-028 Hour arithmetic is modulo 2^WIDTH; no other wrap is reachable.

Reset
REQ-029 cut_n=1 shall override every input and, on the next edge, set every channel to: state IDLE, set=0, count=0, up_r=0, alarm=0.
REQ-030 After reset: alarm=0, buzy_n all 1, and sec/min/hour=0; reset mid-RUN abandons the count with no alarm.

Configuration
REQ-031 Macro TIMER_AUTORELOAD_EN defined: on reaching the terminal value, a channel shall set alarm, reload its count per REQ-016 and stay in RUN (periodic mode); alarm_ack clears only alarm; stop/start behave as in REQ-017/018.
REQ-032 TIMER_AUTORELOAD_EN undefined: DONE behaviour per REQ-022..024 and no reload logic shall be synthesised.

Verification
REQ-033 Reset, write ch0 up=0 0:0:3, start, 3 ticks -> alarm[0]=1 one cycle after the 3rd tick, count 0:0:0, buzy_n[0]=1.
REQ-034 ch1 up=1 target 1:0:0, start, 3600 ticks -> min/sec roll 59->0, hour=1, alarm[1]=1; alarm_ack -> IDLE, count 0:0:0.
REQ-035 ch2 down 0:1:0 running, stop after 5 ticks (0:0:55), 10 ticks while paused -> count unchanged; start -> resumes to 0:0:54 on next tick.
REQ-036 write to a RUN channel with 9:9:9 -> ignored; start+stop together in IDLE -> stays IDLE; insec=75 -> stored as 59.
REQ-037 Reset mid-run on ch0 and ch3 -> all counts 0, alarm=0, buzy_n=all 1 on the next cycle.
REQ-038 With TIMER_AUTORELOAD_EN: down 0:0:2 -> alarm after 2 ticks, count reloads to 0:0:2, buzy_n stays 0, and counting continues.
